// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE sequencing controller.
// Bias states are present only when PE_CTRL_BIAS_EN is defined.
package pe_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CLR      = 4'd1,
        ST_LOAD     = 4'd2,
        ST_MUL_LD   = 4'd3,
        ST_MUL      = 4'd4,
        ST_ADD      = 4'd5,
        ST_ACC_WR   = 4'd6,
`ifdef PE_CTRL_BIAS_EN
        ST_BIAS_LD  = 4'd7,
        ST_BIAS_ADD = 4'd8,
        ST_BIAS_WR  = 4'd9,
`endif
        ST_WB       = 4'd10,
        ST_DONE     = 4'd11,
        ST_PLOAD    = 4'd12,
        ST_POOL     = 4'd13
    } pe_state_e;

    localparam logic OP_CONV  = 1'b0;
    localparam logic OP_POOL  = 1'b1;

    localparam logic SEL_CONV = 1'b0;
    localparam logic SEL_POOL = 1'b1;
    localparam logic SEL_WT   = 1'b0;
    localparam logic SEL_BIAS = 1'b1;
    localparam logic SEL_MULT = 1'b0;
    localparam logic SEL_ACC  = 1'b0;

endpackage

// File: rtl/pe_ctrl_wait.sv
// Waits on one PE unit's done level; the first cycle in the wait state is masked
// because the level may still be high from the previous operation.
module pe_ctrl_wait
    import pe_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic resp,
    output logic hit
);

    logic armed_q;
    logic armed_d;

    // Done detection and arming for the next cycle
    always_comb begin
        hit     = active && armed_q && resp;
        armed_d = active && !hit;
    end

    // Arm register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/pe_ctrl.sv
// Sequencing controller for one PE: conv (MAC loop) and max-pool commands.
// Optional bias phase enabled by defining PE_CTRL_BIAS_EN.
module pe_ctrl
    import pe_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_op,
    input  logic [CNT_WIDTH-1:0] cmd_len,
    input  logic                 opnd_valid,
    output logic                 opnd_ready,
    output logic                 actn_in_sel,
    output logic                 wt_in_sel,
    output logic                 add_in_sel,
    output logic                 pe_out_sel,
    output logic                 if_rf_wr_en,
    output logic                 wt_rf_wr_en,
    output logic                 of_rf_wr_en,
    output logic                 mult_en,
    output logic                 mult_load,
    output logic                 add_en,
    output logic                 acc_wr_en,
    output logic                 acc_clr,
    input  logic [1:0]           pe_resp,
    output logic                 busy,
    output logic                 done
);

    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("pe_ctrl: DATA_WIDTH must be positive");
    end

    localparam logic [CNT_WIDTH-1:0] REM_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] REM_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    pe_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] rem_q, rem_d;
    logic                 op_q, op_d;
    logic                 mul_active_s, add_active_s;
    logic                 mul_hit_s, add_hit_s;

    // Which states wait on the multiplier / adder done levels
    always_comb begin
        mul_active_s = (state_q == ST_MUL);
`ifdef PE_CTRL_BIAS_EN
        add_active_s = (state_q == ST_ADD) || (state_q == ST_BIAS_ADD);
`else
        add_active_s = (state_q == ST_ADD);
`endif
    end

    pe_ctrl_wait u_mul_wait (
        .clk    (clk),
        .rst    (rst),
        .active (mul_active_s),
        .resp   (pe_resp[0]),
        .hit    (mul_hit_s)
    );

    pe_ctrl_wait u_add_wait (
        .clk    (clk),
        .rst    (rst),
        .active (add_active_s),
        .resp   (pe_resp[1]),
        .hit    (add_hit_s)
    );

    // Next-state logic and state-decoded control outputs
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        op_d        = op_q;
        cmd_ready   = 1'b0;
        opnd_ready  = 1'b0;
        actn_in_sel = SEL_CONV;
        wt_in_sel   = SEL_WT;
        add_in_sel  = SEL_MULT;
        pe_out_sel  = SEL_ACC;
        if_rf_wr_en = 1'b0;
        wt_rf_wr_en = 1'b0;
        of_rf_wr_en = 1'b0;
        mult_en     = 1'b0;
        mult_load   = 1'b0;
        add_en      = 1'b0;
        acc_wr_en   = 1'b0;
        acc_clr     = 1'b0;
        busy        = (state_q != ST_IDLE);
        done        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    rem_d   = cmd_len;
                    op_d    = cmd_op;
                    state_d = (cmd_op == OP_POOL) ? ST_PLOAD : ST_CLR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLR: begin
                acc_clr = 1'b1;
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (rem_q == REM_ZERO) begin
`ifdef PE_CTRL_BIAS_EN
                    state_d = ST_BIAS_LD;
`else
                    state_d = ST_WB;
`endif
                end else begin
                    opnd_ready = 1'b1;
                    if (opnd_valid) begin
                        if_rf_wr_en = 1'b1;
                        wt_rf_wr_en = 1'b1;
                        state_d     = ST_MUL_LD;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_MUL_LD: begin
                mult_load = 1'b1;
                state_d   = ST_MUL;
            end
            ST_MUL: begin
                mult_en = 1'b1;
                state_d = mul_hit_s ? ST_ADD : ST_MUL;
            end
            ST_ADD: begin
                add_en     = 1'b1;
                add_in_sel = SEL_MULT;
                state_d    = add_hit_s ? ST_ACC_WR : ST_ADD;
            end
            ST_ACC_WR: begin
                acc_wr_en = 1'b1;
                rem_d     = rem_q - REM_ONE;
                state_d   = ST_LOAD;
            end
`ifdef PE_CTRL_BIAS_EN
            ST_BIAS_LD: begin
                opnd_ready = 1'b1;
                if (opnd_valid) begin
                    wt_rf_wr_en = 1'b1;
                    state_d     = ST_BIAS_ADD;
                end else begin
                    state_d = ST_BIAS_LD;
                end
            end
            ST_BIAS_ADD: begin
                wt_in_sel  = SEL_BIAS;
                add_in_sel = SEL_BIAS;
                add_en     = 1'b1;
                state_d    = add_hit_s ? ST_BIAS_WR : ST_BIAS_ADD;
            end
            ST_BIAS_WR: begin
                acc_wr_en = 1'b1;
                state_d   = ST_WB;
            end
`endif
            ST_WB: begin
                of_rf_wr_en = 1'b1;
                pe_out_sel  = (op_q == OP_POOL) ? SEL_POOL : SEL_ACC;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            ST_PLOAD: begin
                if (rem_q == REM_ZERO) begin
                    state_d = ST_WB;
                end else begin
                    opnd_ready = 1'b1;
                    if (opnd_valid) begin
                        if_rf_wr_en = 1'b1;
                        state_d     = ST_POOL;
                    end else begin
                        state_d = ST_PLOAD;
                    end
                end
            end
            ST_POOL: begin
                actn_in_sel = SEL_POOL;
                rem_d       = rem_q - REM_ONE;
                state_d     = ST_PLOAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, remaining-count and opcode registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rem_q   <= REM_ZERO;
            op_q    <= OP_CONV;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

endmodule
